// File: rtl/paint_pkg.sv
// Shared types and canvas defaults for the paint write path.
package paint_pkg;

  localparam int unsigned CanvasWDefault   = 160;
  localparam int unsigned CanvasHDefault   = 120;
  localparam int unsigned FifoDepthDefault = 8;
  localparam int unsigned BrushRDefault    = 1;

  typedef logic [2:0] color_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    color_t     color;
  } point_t;

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} sched_state_t;

  // Signed 10-bit target lies inside a w x h canvas.
  function automatic logic in_canvas(logic signed [9:0] x, logic signed [9:0] y,
                                     int unsigned w, int unsigned h);
    return !x[9] && !y[9] && ($unsigned(x) < 10'(w)) && ($unsigned(y) < 10'(h));
  endfunction

endpackage

// File: rtl/point_fifo.sv
// Synchronous FIFO of brush points with flush, full/empty flags and async reset.
module point_fifo
  import paint_pkg::*;
#(
  parameter int unsigned DEPTH = FifoDepthDefault
) (
  input  logic   clk,
  input  logic   reset_b,
  input  logic   flush,
  input  logic   push,
  input  point_t din,
  input  logic   pop,
  output point_t dout,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  point_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      // A push landing on the flush cycle survives as the sole entry.
      wr_ptr_q <= do_push ? AW'(1) : '0;
      rd_ptr_q <= '0;
      count_q  <= do_push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[flush ? AW'(0) : wr_ptr_q] <= din;
  end

endmodule

// File: rtl/paint_write_scheduler.sv
// Sequences brush stamps and canvas clears into the framebuffer, writing only during blanking.
module paint_write_scheduler
  import paint_pkg::*;
#(
  parameter int unsigned CANVAS_W   = CanvasWDefault,
  parameter int unsigned CANVAS_H   = CanvasHDefault,
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault,
  parameter int unsigned BRUSH_R    = BrushRDefault
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       pt_valid,
  input  logic [7:0] pt_x,
  input  logic [7:0] pt_y,
  input  logic [2:0] pt_color,
  output logic       pt_ready,
  input  logic       brush_en,
  input  logic       clear_req,
  input  logic [2:0] clear_color,
  input  logic       blank_b,
  output logic       we,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic [2:0] wcolor,
  output logic       busy,
  output logic       overflow
);

  localparam logic signed [9:0] BrushR = 10'(BRUSH_R);
  localparam logic [7:0]        LastX  = 8'(CANVAS_W - 1);
  localparam logic [7:0]        LastY  = 8'(CANVAS_H - 1);

  sched_state_t      state_q, state_d;
  logic [7:0]        cx_q, cx_d, cy_q, cy_d;
  color_t            op_color_q, op_color_d;
  logic signed [9:0] dx_q, dx_d, dy_q, dy_d;
  logic [7:0]        px_q, px_d, py_q, py_d;
  logic              clear_pending_q, clear_pending_d;
  color_t            clear_color_q, clear_color_d;
  logic              we_q, we_d;
  logic [7:0]        wx_q, wx_d, wy_q, wy_d;
  color_t            wcolor_q, wcolor_d;
  logic              overflow_q, overflow_d;
  logic signed [9:0] tx, ty;
  logic              take_clear;

  point_t fifo_din, fifo_dout;
  logic   fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;

  assign fifo_din  = '{x: pt_x, y: pt_y, color: pt_color};
  assign pt_ready  = ~fifo_full;
  // Points offered with the brush off are handshaken but dropped.
  assign fifo_push = pt_valid & pt_ready & brush_en;

  point_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_point_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    op_color_d = op_color_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    px_d       = px_q;
    py_d       = py_q;
    we_d       = 1'b0;
    wx_d       = wx_q;
    wy_d       = wy_q;
    wcolor_d   = wcolor_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    take_clear = 1'b0;
    tx         = '0;
    ty         = '0;

    case (state_q)
      IDLE: begin
        if (clear_pending_q) begin
          fifo_flush = 1'b1;
          take_clear = 1'b1;
          px_d       = '0;
          py_d       = '0;
          op_color_d = clear_color_q;
          state_d    = CLEAR;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cx_d       = fifo_dout.x;
          cy_d       = fifo_dout.y;
          op_color_d = fifo_dout.color;
          dx_d       = -BrushR;
          dy_d       = -BrushR;
          state_d    = PAINT;
        end
      end
      PAINT: begin
        if (!blank_b) begin
          tx = $signed({2'b00, cx_q}) + dx_q;
          ty = $signed({2'b00, cy_q}) + dy_q;
          if (in_canvas(tx, ty, CANVAS_W, CANVAS_H)) begin
            we_d     = 1'b1;
            wx_d     = tx[7:0];
            wy_d     = ty[7:0];
            wcolor_d = op_color_q;
          end
          // Clipped offsets still consume their cycle so stamp timing is fixed.
          if (dx_q == BrushR) begin
            dx_d = -BrushR;
            if (dy_q == BrushR) state_d = IDLE;
            else                dy_d    = dy_q + 10'sd1;
          end else begin
            dx_d = dx_q + 10'sd1;
          end
        end
      end
      CLEAR: begin
        if (!blank_b) begin
          we_d     = 1'b1;
          wx_d     = px_q;
          wy_d     = py_q;
          wcolor_d = op_color_q;
          if (px_q == LastX) begin
            px_d = '0;
            if (py_q == LastY) state_d = IDLE;
            else               py_d    = py_q + 8'd1;
          end else begin
            px_d = px_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A request arriving while one is pending (including on the take cycle) is absorbed.
  always_comb begin
    clear_pending_d = clear_pending_q;
    clear_color_d   = clear_color_q;
    if (take_clear) begin
      clear_pending_d = 1'b0;
    end else if (clear_req && !clear_pending_q) begin
      clear_pending_d = 1'b1;
      clear_color_d   = clear_color;
    end
  end

  assign overflow_d = overflow_q | (pt_valid & ~pt_ready);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q         <= IDLE;
      cx_q            <= '0;
      cy_q            <= '0;
      op_color_q      <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
      px_q            <= '0;
      py_q            <= '0;
      clear_pending_q <= 1'b0;
      clear_color_q   <= '0;
      we_q            <= 1'b0;
      wx_q            <= '0;
      wy_q            <= '0;
      wcolor_q        <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cx_q            <= cx_d;
      cy_q            <= cy_d;
      op_color_q      <= op_color_d;
      dx_q            <= dx_d;
      dy_q            <= dy_d;
      px_q            <= px_d;
      py_q            <= py_d;
      clear_pending_q <= clear_pending_d;
      clear_color_q   <= clear_color_d;
      we_q            <= we_d;
      wx_q            <= wx_d;
      wy_q            <= wy_d;
      wcolor_q        <= wcolor_d;
      overflow_q      <= overflow_d;
    end
  end

  assign we       = we_q;
  assign wx       = wx_q;
  assign wy       = wy_q;
  assign wcolor   = wcolor_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty | clear_pending_q;

endmodule

// File: tb/tb_paint_write_scheduler.sv
// Scoreboard bench: expected writes are queued at stimulus time and matched by a monitor.
module tb_paint_write_scheduler;

  logic       clk;
  logic       reset_b;
  logic       pt_valid;
  logic [7:0] pt_x, pt_y;
  logic [2:0] pt_color;
  logic       pt_ready;
  logic       brush_en;
  logic       clear_req;
  logic [2:0] clear_color;
  logic       blank_b;
  logic       we;
  logic [7:0] wx, wy;
  logic [2:0] wcolor;
  logic       busy;
  logic       overflow;

  typedef struct {
    int x;
    int y;
    int c;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  logic hold_chk = 1'b0;

  paint_write_scheduler dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .pt_valid    (pt_valid),
    .pt_x        (pt_x),
    .pt_y        (pt_y),
    .pt_color    (pt_color),
    .pt_ready    (pt_ready),
    .brush_en    (brush_en),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .blank_b     (blank_b),
    .we          (we),
    .wx          (wx),
    .wy          (wy),
    .wcolor      (wcolor),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pt(input int x, input int y, input int c);
    pt_valid = 1'b1;
    pt_x     = 8'(x);
    pt_y     = 8'(y);
    pt_color = 3'(c);
    tick();
    pt_valid = 1'b0;
  endtask

  task automatic expect_stamp(input int x, input int y, input int c);
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        int tx;
        int ty;
        tx = x + dx;
        ty = y + dy;
        if (tx >= 0 && tx < 160 && ty >= 0 && ty < 120) exp_q.push_back('{tx, ty, c});
      end
    end
  endtask

  // Counts busy negedges until busy drops; an expired budget is a failure.
  task automatic wait_idle(input int limit, output int n);
    int g;
    n = 0;
    g = 0;
    while (g < limit) begin
      @(negedge clk);
      g++;
      if (busy) n++;
      else break;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle_timeout busy=%0b required=0", busy);
    end
    tick();
  endtask

  initial begin
    int n;
    reset_b     = 1'b0;
    pt_valid    = 1'b0;
    pt_x        = '0;
    pt_y        = '0;
    pt_color    = '0;
    brush_en    = 1'b0;
    clear_req   = 1'b0;
    clear_color = '0;
    blank_b     = 1'b0;

    fork
      begin
        wr_t e;
        forever begin
          @(negedge clk);
          if (reset_b && we) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_write got=(%0d,%0d,c%0d) required=none", wx, wy, wcolor);
            end else begin
              e = exp_q.pop_front();
              if (int'(wx) != e.x || int'(wy) != e.y || int'(wcolor) != e.c) begin
                bad++;
                $display("FAIL write got=(%0d,%0d,c%0d) required=(%0d,%0d,c%0d)",
                         wx, wy, wcolor, e.x, e.y, e.c);
              end
            end
          end
          if (hold_chk) check("hold_no_we", int'(we), 0);
        end
      end
    join_none

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_we", int'(we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_pt_ready", int'(pt_ready), 1);
    reset_b = 1'b1;
    tick();

    // Brush disabled: the point is dropped.
    push_pt(70, 70, 7);
    tick();
    check("brush_off_busy", int'(busy), 0);
    brush_en = 1'b1;

    // 2: interior stamp
    expect_stamp(10, 20, 3);
    push_pt(10, 20, 3);
    wait_idle(100, n);
    check("stamp_busy_cycles", n, 10);
    check("stamp_drained", exp_q.size(), 0);
    check("stamp_idle_busy", int'(busy), 0);

    // 3: corner stamp, clipped but full length
    expect_stamp(0, 0, 6);
    push_pt(0, 0, 6);
    wait_idle(100, n);
    check("corner_busy_cycles", n, 10);
    check("corner_drained", exp_q.size(), 0);

    // 4: blanking hold mid-stamp
    expect_stamp(50, 60, 2);
    push_pt(50, 60, 2);
    repeat (3) tick();
    blank_b = 1'b1;
    tick();
    hold_chk = 1'b1;
    repeat (49) tick();
    hold_chk = 1'b0;
    blank_b  = 1'b0;
    wait_idle(100, n);
    check("hold_drained", exp_q.size(), 0);

    // 5: fill the queue behind a stalled stamp, then overflow
    blank_b = 1'b1;
    expect_stamp(100, 100, 1);
    push_pt(100, 100, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("fill_ready", int'(pt_ready), 1);
      expect_stamp(20 + 15 * i, 60, i);
      push_pt(20 + 15 * i, 60, i);
    end
    check("full_pt_ready", int'(pt_ready), 0);
    check("pre_overflow", int'(overflow), 0);
    push_pt(5, 5, 5);
    check("overflow_set", int'(overflow), 1);
    blank_b = 1'b0;
    wait_idle(300, n);
    check("full_drained", exp_q.size(), 0);
    check("overflow_sticky", int'(overflow), 1);

    // 6: clear requested mid-stamp with points queued
    blank_b = 1'b1;
    expect_stamp(30, 40, 4);
    push_pt(30, 40, 4);
    tick();
    push_pt(80, 80, 1);
    push_pt(90, 90, 2);
    push_pt(100, 50, 3);
    blank_b = 1'b0;
    repeat (3) tick();
    clear_req   = 1'b1;
    clear_color = 3'd5;
    tick();
    clear_req = 1'b0;
    tick();
    clear_req   = 1'b1;
    clear_color = 3'd2;
    tick();
    clear_req = 1'b0;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) exp_q.push_back('{x, y, 5});
    wait_idle(25000, n);
    repeat (20) tick();
    check("clear_drained", exp_q.size(), 0);
    check("clear_idle_busy", int'(busy), 0);
    check("clear_last_x", int'(wx), 159);
    check("clear_last_y", int'(wy), 119);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
